// File: rtl/axil_seq_pattern_master.sv
// rtl/axil_seq_pattern_master.sv - AXI4-Lite write-then-readback pattern self-test master
// Writes NUM_WORDS pattern words, reads them back, reports errors and first failing address.
module axil_seq_pattern_master #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_WORDS      = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [31:0]             seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [15:0]             error_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RD, S_RR, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [31:0]             seed_q, seed_d;
  logic [1:0]              mode_q, mode_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    timeout_q, timeout_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]   first_err_q, first_err_d;

  logic                    aw_fire, w_fire, b_fire, ar_fire, r_fire, any_fire;
  logic                    err_now, waiting;
  logic [31:0]             idx_ext;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   exp_data;

  function automatic logic [31:0] pattern(input logic [1:0] m, input logic [31:0] s,
                                          input logic [31:0] i);
    logic [31:0] p;
    case (m)
      2'd1:    p = 32'd1 << i[4:0];
      2'd2:    p = ~(s + i);
      default: p = s + i;
    endcase
    return p;
  endfunction

  assign idx_ext  = 32'(idx_q);
  assign cur_addr = BASE_ADDR + (ADDR_WIDTH'(idx_q) << 2);
  // Mode 3 checks against mode-0 data without writing it first.
  assign exp_data = DATA_WIDTH'(pattern((mode_q == 2'd3) ? 2'd0 : mode_q, seed_q, idx_ext));

  assign m_axi_awaddr  = cur_addr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = (state_q == S_WR) && !aw_done_q;
  assign m_axi_wdata   = DATA_WIDTH'(pattern(mode_q, seed_q, idx_ext));
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state_q == S_WR) && !w_done_q;
  assign m_axi_bready  = (state_q == S_WB);
  assign m_axi_araddr  = cur_addr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_q == S_RD);
  assign m_axi_rready  = (state_q == S_RR);

  assign aw_fire  = m_axi_awvalid && m_axi_awready;
  assign w_fire   = m_axi_wvalid && m_axi_wready;
  assign b_fire   = m_axi_bready && m_axi_bvalid;
  assign ar_fire  = m_axi_arvalid && m_axi_arready;
  assign r_fire   = m_axi_rready && m_axi_rvalid;
  assign any_fire = aw_fire || w_fire || b_fire || ar_fire || r_fire;
  assign waiting  = (state_q == S_WR) || (state_q == S_WB) || (state_q == S_RD) || (state_q == S_RR);

  assign busy           = waiting;
  assign done           = (state_q == S_DONE);
  assign timeout        = timeout_q;
  assign error_count    = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign pass           = done && (err_cnt_q == 16'd0) && !timeout_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    seed_d      = seed_q;
    mode_d      = mode_q;
    aw_done_d   = aw_done_q || aw_fire;
    w_done_d    = w_done_q || w_fire;
    tmo_d       = tmo_q;
    timeout_d   = timeout_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    err_now     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_cnt_d   = '0;
          first_err_d = '0;
          timeout_d   = 1'b0;
          idx_d       = '0;
          seed_d      = seed;
          mode_d      = mode;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          tmo_d       = '0;
          state_d     = (mode == 2'd3) ? S_RD : S_WR;
        end
      end
      S_WR: begin
        if (aw_done_d && w_done_d) state_d = S_WB;
      end
      S_WB: begin
        if (m_axi_bvalid) begin
          err_now   = (m_axi_bresp != 2'b00);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_RD;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_WR;
          end
        end
      end
      S_RD: begin
        if (ar_fire) state_d = S_RR;
      end
      S_RR: begin
        if (m_axi_rvalid) begin
          err_now = (m_axi_rdata != exp_data) || (m_axi_rresp != 2'b00);
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err_now) begin
      if (err_cnt_q == 16'd0) first_err_d = cur_addr;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    // The counter measures stall on the current handshake only; progress of any kind resets it.
    if (waiting) begin
      if ((state_d != state_q) || any_fire) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LIMIT) begin
        tmo_d     = '0;
        timeout_d = 1'b1;
        state_d   = S_DONE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      seed_q      <= '0;
      mode_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      tmo_q       <= '0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seed_q      <= seed_d;
      mode_q      <= mode_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      tmo_q       <= tmo_d;
      timeout_q   <= timeout_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

endmodule

// File: tb/tb_axil_seq_pattern_master.sv
// tb/tb_axil_seq_pattern_master.sv - randomized AXI4-Lite slave plus reference model for the pattern master
module tb_axil_seq_pattern_master;

  localparam int          NW   = 34;
  localparam int          TMO  = 64;
  localparam logic [31:0] BASE = 32'h40;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic        busy, done, pass, timeout;
  logic [15:0] error_count;
  logic [31:0] first_err_addr;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  always #5 clock = ~clock;

  axil_seq_pattern_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(NW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .error_count(error_count), .first_err_addr(first_err_addr),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  bit rand_ready    = 1'b0;
  bit stall_ar      = 1'b0;
  int aw_fix        = -1;
  int w_fix         = -1;
  int corrupt_idx   = -1;
  int bresp_err_idx = -1;
  int rresp_err_idx = -1;

  int writes, reads, violations, ar_hi;

  bit          aw_got, w_got, b_pend, b_err, r_pend, r_err;
  logic [31:0] aw_a, w_d, r_data;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int          aw_need, w_need, b_need, ar_need, r_need;
  bit          aw_pv, w_pv, ar_pv;
  logic [31:0] aw_pa, w_pd, ar_pa;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int m, input logic [31:0] s, input int i);
    case (m)
      1:       return 32'h1 << (i % 32);
      2:       return ~(s + 32'(i));
      default: return s + 32'(i);
    endcase
  endfunction

  function automatic int slot(input int i);
    return (int'(BASE >> 2) + i) % 64;
  endfunction

  function automatic int aidx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic int draw(input int fix);
    if (fix >= 0) return fix;
    return rand_ready ? int'($urandom_range(0, 3)) : 0;
  endfunction

  task automatic slave_clear();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;    m_axi_rresp = 2'b00;
    aw_got = 0; w_got = 0; b_pend = 0; b_err = 0; r_pend = 0; r_err = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_need = draw(aw_fix); w_need = draw(w_fix); b_need = 0; ar_need = draw(-1); r_need = 0;
    aw_pv = 0; w_pv = 0; ar_pv = 0;
  endtask

  // Slave: outputs are set at negedge, handshakes are judged 1 time unit later with values
  // that stay stable up to the next posedge.
  initial begin
    slave_clear();
    forever begin
      @(negedge clock);
      if (reset) begin
        slave_clear();
        continue;
      end
      m_axi_awready = m_axi_awvalid && !aw_got && !b_pend && (aw_cnt >= aw_need);
      m_axi_wready  = m_axi_wvalid && !w_got && !b_pend && (w_cnt >= w_need);
      m_axi_bvalid  = b_pend && (b_cnt >= b_need);
      m_axi_bresp   = b_err ? 2'b10 : 2'b00;
      m_axi_arready = m_axi_arvalid && !r_pend && !stall_ar && (ar_cnt >= ar_need);
      m_axi_rvalid  = r_pend && (r_cnt >= r_need);
      m_axi_rdata   = r_data;
      m_axi_rresp   = r_err ? 2'b10 : 2'b00;
      #1;
      if (m_axi_bready && !b_pend) violations++;
      if (m_axi_rready && !r_pend) violations++;
      if (m_axi_awvalid && (aw_got || b_pend)) violations++;
      if (m_axi_wvalid && (w_got || b_pend)) violations++;
      if (m_axi_arvalid && r_pend) violations++;
      if (m_axi_awprot != 3'b000 || m_axi_arprot != 3'b000 || m_axi_wstrb != 4'hF) violations++;
      if (aw_pv && (!m_axi_awvalid || m_axi_awaddr != aw_pa)) violations++;
      if (w_pv && (!m_axi_wvalid || m_axi_wdata != w_pd)) violations++;
      if (ar_pv && (!m_axi_arvalid || m_axi_araddr != ar_pa)) violations++;
      aw_pv = m_axi_awvalid && !m_axi_awready; aw_pa = m_axi_awaddr;
      w_pv  = m_axi_wvalid && !m_axi_wready;   w_pd  = m_axi_wdata;
      ar_pv = m_axi_arvalid && !m_axi_arready; ar_pa = m_axi_araddr;
      if (m_axi_arvalid) ar_hi++;

      if (m_axi_awvalid && m_axi_awready) begin
        aw_got = 1; aw_a = m_axi_awaddr; aw_cnt = 0; aw_need = draw(aw_fix);
      end else if (m_axi_awvalid) aw_cnt++;
      if (m_axi_wvalid && m_axi_wready) begin
        w_got = 1; w_d = m_axi_wdata; w_cnt = 0; w_need = draw(w_fix);
      end else if (m_axi_wvalid) w_cnt++;
      if (m_axi_bvalid && m_axi_bready) b_pend = 0;
      else if (b_pend) b_cnt++;
      if (aw_got && w_got) begin
        mem[aw_a[7:2]] = w_d;
        writes++;
        b_err  = (aidx(aw_a) == bresp_err_idx);
        b_pend = 1; b_cnt = 0; b_need = draw(-1);
        aw_got = 0; w_got = 0;
      end
      if (m_axi_rvalid && m_axi_rready) r_pend = 0;
      else if (r_pend) r_cnt++;
      if (m_axi_arvalid && m_axi_arready) begin
        reads++;
        r_pend = 1;
        r_data = (aidx(m_axi_araddr) == corrupt_idx) ? 32'h0000DEAD : mem[m_axi_araddr[7:2]];
        r_err  = (aidx(m_axi_araddr) == rresp_err_idx);
        r_cnt = 0; r_need = draw(-1); ar_cnt = 0; ar_need = draw(-1);
      end else if (m_axi_arvalid) ar_cnt++;
    end
  end

  // Reference: writes land in ref_mem in order, then every word is read and judged once.
  task automatic model_run(input int m, input logic [31:0] s, output int e_err,
                           output logic [31:0] e_first);
    logic [31:0] got;
    e_err = 0; e_first = '0;
    if (m != 3) begin
      for (int i = 0; i < NW; i++) begin
        if (i == bresp_err_idx) begin
          if (e_err == 0) e_first = BASE + 32'(4 * i);
          e_err++;
        end
        ref_mem[slot(i)] = pat(m, s, i);
      end
    end
    for (int i = 0; i < NW; i++) begin
      got = (i == corrupt_idx) ? 32'h0000DEAD : ref_mem[slot(i)];
      if (got != pat((m == 3) ? 0 : m, s, i) || i == rresp_err_idx) begin
        if (e_err == 0) e_first = BASE + 32'(4 * i);
        e_err++;
      end
    end
  endtask

  task automatic launch(input int m, input logic [31:0] s);
    writes = 0; reads = 0; violations = 0; ar_hi = 0;
    mode = 2'(m); seed = s;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 0;
    for (int c = 0; c < 20000; c++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clock);
    end
    chk({tag, "_done_reached"}, 32'(seen), 32'd1);
  endtask

  task automatic check_result(input string tag, input int e_err, input logic [31:0] e_first,
                              input int e_wr, input int e_rd, input bit e_to);
    chk({tag, "_busy"},       32'(busy), 32'd0);
    chk({tag, "_done"},       32'(done), 32'd1);
    chk({tag, "_timeout"},    32'(timeout), 32'(e_to));
    chk({tag, "_err_count"},  32'(error_count), 32'(e_err));
    chk({tag, "_first_err"},  first_err_addr, e_first);
    chk({tag, "_pass"},       32'(pass), 32'((e_err == 0) && !e_to));
    chk({tag, "_writes"},     32'(writes), 32'(e_wr));
    chk({tag, "_reads"},      32'(reads), 32'(e_rd));
    chk({tag, "_violations"}, 32'(violations), 32'd0);
  endtask

  task automatic full_run(input string tag, input int m, input logic [31:0] s);
    int e_err;
    logic [31:0] e_first;
    model_run(m, s, e_err, e_first);
    launch(m, s);
    wait_done(tag);
    check_result(tag, e_err, e_first, (m == 3) ? 0 : NW, NW, 1'b0);
  endtask

  initial begin
    int e_err, k;
    logic [31:0] e_first, s_a, s_c;
    bit seen;

    reset = 1'b1; start = 1'b0; mode = 2'd0; seed = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_err_count", 32'(error_count), 32'd0);
    chk("rst_first_err", first_err_addr, 32'd0);
    chk("rst_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    full_run("m0_seed1", 0, 32'd1);
    chk("m0_word0", mem[slot(0)], 32'd1);
    chk("m0_word3", mem[slot(3)], 32'd4);

    rand_ready = 1'b1;
    full_run("m1_walk", 1, $urandom);
    chk("m1_word33", mem[slot(33)], 32'h00000002);
    chk("m1_word31", mem[slot(31)], 32'h80000000);

    full_run("m2_inv", 2, $urandom);
    full_run("m2_wrap", 2, 32'hFFFF_FFF0);
    chk("m2_wrap_word16", mem[slot(16)], 32'hFFFF_FFFF);

    rand_ready = 1'b0; aw_fix = 3; w_fix = 0;
    slave_clear();
    full_run("w_before_aw", 0, $urandom);
    aw_fix = -1; w_fix = -1; rand_ready = 1'b1;

    corrupt_idx = 2;
    full_run("corrupt2", 0, 32'd1);
    chk("corrupt2_addr", first_err_addr, BASE + 32'h8);

    bresp_err_idx = 5; rresp_err_idx = 2;
    full_run("bresp_rresp", 0, $urandom);
    corrupt_idx = -1; bresp_err_idx = -1; rresp_err_idx = -1;

    s_a = $urandom;
    model_run(0, s_a, e_err, e_first);
    launch(0, s_a);
    repeat (20) @(negedge clock);
    mode = 2'd2; seed = ~s_a; start = 1'b1;
    @(negedge clock); start = 1'b0;
    wait_done("start_busy");
    check_result("start_busy", e_err, e_first, NW, NW, 1'b0);
    chk("start_busy_word0", mem[slot(0)], s_a);

    stall_ar = 1'b1;
    launch(3, $urandom);
    wait_done("tmo");
    check_result("tmo", 0, 32'd0, 0, 0, 1'b1);
    chk("tmo_arvalid", 32'(m_axi_arvalid), 32'd0);
    chk("tmo_ar_cycles", 32'(ar_hi), 32'(TMO));
    stall_ar = 1'b0;

    s_c = $urandom;
    launch(0, s_c);
    seen = 0;
    for (int c = 0; c < 5000; c++) begin
      if (m_axi_bready && writes >= 3) begin
        seen = 1;
        break;
      end
      @(negedge clock);
    end
    chk("mid_wb_reached", 32'(seen), 32'd1);
    k = writes;
    for (int i = 0; i < k; i++) ref_mem[slot(i)] = pat(0, s_c, i);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valids", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_done", 32'(done), 32'd0);
    full_run("ro_after_rst", 3, s_c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_seq_pattern_master.md
Name: axil_seq_pattern_master

Overview:
Synthesizable AXI4-Lite master that runs a parametrised write-then-readback sequence against any AXI4-Lite slave (e.g. the fisrIP register bank). It writes NUM_WORDS data-pattern words from BASE_ADDR in 4-byte steps. It then reads them back, compares each word, and reports pass/fail, the error count and the first failing address. It sits beside the IP in self-test block designs and replaces bench-only sequential access with on-chip checking.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, AXI data width; only 32 is supported; wstrb is all ones.
NUM_WORDS, 4, words per sequence; must be ≥1.
BASE_ADDR, 0, byte address of the first word.
TIMEOUT_CYCLES, 1024, maximum cycles waiting on any single handshake or response.

Ports:
clock  in  1  clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; ignored unless the block is in IDLE or DONE.
mode  in  2  data pattern: 0 = seed+i; 1 = walking one (1<<(i mod 32)); 2 = ~(seed+i); 3 = read-only check against mode-0 data.
seed  in  32  pattern seed, sampled on start.
busy  out  1  high from start acceptance until DONE.
done  out  1  high in DONE until the next accepted start.
pass  out  1  valid while done: 1 when error_count==0 and timeout==0.
timeout  out  1  a handshake exceeded TIMEOUT_CYCLES.
error_count  out  16  mismatches plus non-OKAY responses; saturates at 0xFFFF.
first_err_addr  out  ADDR_WIDTH  address of the first error; 0 when there is none.
m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_WIDTH/3/1/1  write address channel; prot=0.
m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data channel.
m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel.
m_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_WIDTH/3/1/1  read address channel; prot=0.
m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data channel.

Behaviour:
- Reset: state=IDLE. All valid/ready outputs, busy, done, pass, timeout, error_count, first_err_addr and the index are 0.
- States:
  - IDLE/DONE --start--> WR (mode 0-2) or RD (mode 3). Start clears error_count, first_err_addr, timeout and done; index i=0; seed and mode are latched.
  - WR: awvalid and wvalid rise together in the cycle after entry. addr = BASE_ADDR+4*i; data = pattern(i). Each valid drops in the cycle after its own handshake (valid&&ready). The two handshakes may complete in either order or together. Go to WB when both are done.
  - WB: bready=1. On bvalid: a bresp≠0 counts one error. If i==NUM_WORDS-1 then i=0 and go to RD; else i++ and return to WR.
  - RD: arvalid=1 with araddr = BASE_ADDR+4*i. On handshake go to RR.
  - RR: rready=1. On rvalid: compare rdata with the expected pattern(i). A mismatch or rresp≠0 counts one error (one per beat, never two). If i==NUM_WORDS-1 go to DONE; else i++ and return to RD.
- AXI rule: once asserted, valid and address/data stay stable until the handshake. Only one transaction is outstanding at a time.
- first_err_addr is loaded only on an error while error_count==0.
- Timeout: a counter clears on every state entry and on every handshake. It increments while waiting in WR/WB/RD/RR. When it reaches TIMEOUT_CYCLES: set timeout=1, deassert all valid/ready and go to DONE (abort).
- busy = state∉{IDLE,DONE}. done = state==DONE. pass is combinational from done, error_count and timeout.
- Reset mid-transaction returns to IDLE within one cycle; valids drop at that edge. The slave must also be reset.
- A start pulse while busy has no effect.
- Pattern arithmetic is modulo 2^32. Address arithmetic is modulo 2^ADDR_WIDTH.

Test Plan:
- Mode 0, seed=1, NUM_WORDS=4, slave is the fisrIP register file with ready held high → writes 1,2,3,4 to 0x0,0x4,0x8,0xC; reads match; done with pass=1, error_count=0.
- Mode 1 with NUM_WORDS=34 on a memory slave → word 33 (i=33) = 0x00000002; pass=1.
- Slave asserts wready 3 cycles before awready → both captured exactly once; no duplicate write; bready is seen only after both handshakes.
- Slave word 2 corrupted to 0xDEAD, mode 0, seed=1 → error_count=1, first_err_addr=0x8, pass=0.
- Slave never asserts arready, TIMEOUT_CYCLES=16 → timeout=1 after 16 waiting cycles; arvalid=0; done=1; pass=0.
- Reset pulse during WB, then start with mode 3 → no writes issued; only 4 reads; error_count reflects prior contents.
